// File: rtl/my_design.sv
// fp32 matrix-multiply engine C = A x B over three external synchronous SRAMs; optional DIM_CHECK_EN rejects bad dimensions.
// Latency: RD_DIM + LD_DIM, then K+2 cycles per C element (K reads, one drain, one write), then DONE.
// Backpressure: none; dut_valid is only sampled in IDLE, and dut_ready stays low while a job is in flight.
module my_design #(
    parameter int SRAM_ADDR_WIDTH = 16,
    parameter int SRAM_DATA_WIDTH = 32
) (
    input  logic                       clk,
    input  logic                       reset_n,
    input  logic                       dut_valid,
    output logic                       dut_ready,
    output logic                       dut__tb__sram_input_write_enable,
    output logic [SRAM_ADDR_WIDTH-1:0] dut__tb__sram_input_write_address,
    output logic [SRAM_DATA_WIDTH-1:0] dut__tb__sram_input_write_data,
    output logic [SRAM_ADDR_WIDTH-1:0] dut__tb__sram_input_read_address,
    input  logic [SRAM_DATA_WIDTH-1:0] tb__dut__sram_input_read_data,
    output logic                       dut__tb__sram_weight_write_enable,
    output logic [SRAM_ADDR_WIDTH-1:0] dut__tb__sram_weight_write_address,
    output logic [SRAM_DATA_WIDTH-1:0] dut__tb__sram_weight_write_data,
    output logic [SRAM_ADDR_WIDTH-1:0] dut__tb__sram_weight_read_address,
    input  logic [SRAM_DATA_WIDTH-1:0] tb__dut__sram_weight_read_data,
    output logic                       dut__tb__sram_result_write_enable,
    output logic [SRAM_ADDR_WIDTH-1:0] dut__tb__sram_result_write_address,
    output logic [SRAM_DATA_WIDTH-1:0] dut__tb__sram_result_write_data,
    output logic [SRAM_ADDR_WIDTH-1:0] dut__tb__sram_result_read_address,
    input  logic [SRAM_DATA_WIDTH-1:0] tb__dut__sram_result_read_data
);

    localparam int AW = SRAM_ADDR_WIDTH;
    localparam logic [31:0] QNAN = 32'h7FC0_0000;

    typedef enum logic [2:0] {S_IDLE, S_RD_DIM, S_LD_DIM, S_MAC, S_WRITE, S_DONE} state_t;

    state_t          state, state_nxt;
    logic [15:0]     m_dim, k_dim, n_dim;
    logic [15:0]     i_cnt, j_cnt, k_cnt;
    logic [AW-1:0]   a_row, a_addr, b_col, b_addr, c_addr;
    logic [31:0]     acc, prod, acc_sum;
    logic            pend, issue, last_col, last_row, dims_bad;
    logic            unused_bits;

    // RNE multiply, denormal inputs/outputs flushed to signed zero.
    function automatic logic [31:0] fp_mul(input logic [31:0] a, input logic [31:0] b);
        logic               s, g, st;
        logic [47:0]        p;
        logic [23:0]        m;
        logic [24:0]        mr;
        logic signed [10:0] e;
        logic [31:0]        r;
        s  = a[31] ^ b[31];
        g  = 1'b0;
        st = 1'b0;
        p  = '0;
        m  = '0;
        mr = '0;
        e  = '0;
        r  = {s, 31'd0};
        if ((a[30:23] == 8'hFF && a[22:0] != 23'd0) || (b[30:23] == 8'hFF && b[22:0] != 23'd0)) begin
            r = QNAN;
        end else if (a[30:23] == 8'hFF || b[30:23] == 8'hFF) begin
            // inf * 0 is invalid; otherwise infinity carries the product sign
            r = (a[30:23] == 8'd0 || b[30:23] == 8'd0) ? QNAN : {s, 8'hFF, 23'd0};
        end else if (a[30:23] == 8'd0 || b[30:23] == 8'd0) begin
            r = {s, 31'd0};
        end else begin
            p = {24'd0, 1'b1, a[22:0]} * {24'd0, 1'b1, b[22:0]};
            e = $signed({3'd0, a[30:23]}) + $signed({3'd0, b[30:23]}) - 11'sd127;
            if (p[47]) begin
                m  = p[47:24];
                g  = p[23];
                st = |p[22:0];
                e  = e + 11'sd1;
            end else begin
                m  = p[46:23];
                g  = p[22];
                st = |p[21:0];
            end
            mr = {1'b0, m} + {24'd0, g & (st | m[0])};
            if (mr[24]) begin
                mr = mr >> 1;
                e  = e + 11'sd1;
            end
            if (e >= 11'sd255)    r = {s, 8'hFF, 23'd0};
            else if (e <= 11'sd0) r = {s, 31'd0};
            else                  r = {s, e[7:0], mr[22:0]};
        end
        return r;
    endfunction

    // RNE add with three extra bits (guard, round, sticky) on the aligned mantissas.
    function automatic logic [31:0] fp_add(input logic [31:0] a, input logic [31:0] b);
        logic               a_nan, b_nan, a_inf, b_inf;
        logic [31:0]        lg, sm, r;
        logic [7:0]         dexp;
        logic [4:0]         dsh, lz;
        logic [50:0]        sh;
        logic [26:0]        ml, ms, nrm;
        logic [27:0]        sum;
        logic [24:0]        mr;
        logic signed [10:0] e;
        a_nan = (a[30:23] == 8'hFF) && (a[22:0] != 23'd0);
        b_nan = (b[30:23] == 8'hFF) && (b[22:0] != 23'd0);
        a_inf = (a[30:23] == 8'hFF) && (a[22:0] == 23'd0);
        b_inf = (b[30:23] == 8'hFF) && (b[22:0] == 23'd0);
        lg = a;  sm = b;  r = QNAN;
        dexp = '0; dsh = '0; lz = '0; sh = '0;
        ml = '0; ms = '0; nrm = '0; sum = '0; mr = '0; e = '0;
        if (a_nan || b_nan) begin
            r = QNAN;
        end else if (a_inf && b_inf) begin
            r = (a[31] != b[31]) ? QNAN : a;
        end else if (a_inf) begin
            r = a;
        end else if (b_inf) begin
            r = b;
        end else if (a[30:23] == 8'd0) begin
            r = (b[30:23] == 8'd0) ? {a[31] & b[31], 31'd0} : b;
        end else if (b[30:23] == 8'd0) begin
            r = a;
        end else begin
            if (b[30:0] > a[30:0]) begin
                lg = b;
                sm = a;
            end
            dexp = lg[30:23] - sm[30:23];
            // beyond 27 places the smaller operand only contributes sticky
            dsh  = (dexp > 8'd27) ? 5'd27 : dexp[4:0];
            sh   = {1'b1, sm[22:0], 27'd0} >> dsh;
            ms   = sh[50:24] | {26'd0, |sh[23:0]};
            ml   = {1'b1, lg[22:0], 3'd0};
            if (lg[31] == sm[31]) sum = {1'b0, ml} + {1'b0, ms};
            else                  sum = {1'b0, ml - ms};
            e = $signed({3'd0, lg[30:23]});
            if (sum == 28'd0) begin
                r = 32'd0;
            end else begin
                if (sum[27]) begin
                    nrm = {sum[27:2], sum[1] | sum[0]};
                    e   = e + 11'sd1;
                end else begin
                    for (int bi = 0; bi < 27; bi++) begin
                        if (sum[bi]) lz = 5'(26 - bi);
                    end
                    nrm = sum[26:0] << lz;
                    e   = e - $signed({6'd0, lz});
                end
                mr = {1'b0, nrm[26:3]} + {24'd0, nrm[2] & (nrm[3] | nrm[1] | nrm[0])};
                if (mr[24]) begin
                    mr = mr >> 1;
                    e  = e + 11'sd1;
                end
                if (e >= 11'sd255)    r = {lg[31], 8'hFF, 23'd0};
                else if (e <= 11'sd0) r = {lg[31], 31'd0};
                else                  r = {lg[31], e[7:0], mr[22:0]};
            end
        end
        return r;
    endfunction

    assign issue    = (state == S_MAC) && (k_cnt != k_dim);
    assign last_col = (j_cnt == n_dim - 16'd1);
    assign last_row = (i_cnt == m_dim - 16'd1);
    assign dims_bad = (tb__dut__sram_input_read_data[31:16] == 16'd0) ||
                      (tb__dut__sram_input_read_data[15:0] == 16'd0) ||
                      (tb__dut__sram_weight_read_data[15:0] == 16'd0) ||
                      (tb__dut__sram_input_read_data[15:0] != tb__dut__sram_weight_read_data[31:16]);
    assign unused_bits = ^{tb__dut__sram_result_read_data, dims_bad};

    // One multiply-accumulate step on the pair returned by the SRAMs this cycle.
    always_comb begin
        prod    = fp_mul(tb__dut__sram_input_read_data[31:0], tb__dut__sram_weight_read_data[31:0]);
        acc_sum = fp_add(acc, prod);
    end

    // State register.
    always_ff @(posedge clk) begin
        if (reset_n) state <= S_IDLE;
        else         state <= state_nxt;
    end

    // Next-state and SRAM-facing outputs.
    always_comb begin
        state_nxt = state;
        dut_ready = 1'b0;
        dut__tb__sram_input_write_enable   = 1'b0;
        dut__tb__sram_input_write_address  = '0;
        dut__tb__sram_input_write_data     = '0;
        dut__tb__sram_input_read_address   = '0;
        dut__tb__sram_weight_write_enable  = 1'b0;
        dut__tb__sram_weight_write_address = '0;
        dut__tb__sram_weight_write_data    = '0;
        dut__tb__sram_weight_read_address  = '0;
        dut__tb__sram_result_write_enable  = 1'b0;
        dut__tb__sram_result_write_address = '0;
        dut__tb__sram_result_write_data    = '0;
        dut__tb__sram_result_read_address  = '0;
        case (state)
            S_IDLE: begin
                dut_ready = 1'b1;
                if (dut_valid) state_nxt = S_RD_DIM;
            end
            S_RD_DIM: state_nxt = S_LD_DIM;
            S_LD_DIM: begin
`ifdef DIM_CHECK_EN
                state_nxt = dims_bad ? S_DONE : S_MAC;
`else
                state_nxt = S_MAC;
`endif
            end
            S_MAC: begin
                dut__tb__sram_input_read_address  = a_addr;
                dut__tb__sram_weight_read_address = b_addr;
                if (k_cnt == k_dim) state_nxt = S_WRITE;
            end
            S_WRITE: begin
                dut__tb__sram_result_write_enable  = 1'b1;
                dut__tb__sram_result_write_address = c_addr;
                dut__tb__sram_result_write_data    = SRAM_DATA_WIDTH'(acc);
                state_nxt = (last_col && last_row) ? S_DONE : S_MAC;
            end
            S_DONE: begin
                dut_ready = 1'b1;
                state_nxt = S_IDLE;
            end
            default: state_nxt = S_IDLE;
        endcase
    end

    // Dimension latch, index/address walkers and the accumulator.
    always_ff @(posedge clk) begin
        if (reset_n) begin
            m_dim <= '0; k_dim <= '0; n_dim <= '0;
            i_cnt <= '0; j_cnt <= '0; k_cnt <= '0;
            a_row <= '0; a_addr <= '0; b_col <= '0; b_addr <= '0; c_addr <= '0;
            acc   <= '0;
            pend  <= 1'b0;
        end else begin
            case (state)
                S_LD_DIM: begin
                    m_dim  <= tb__dut__sram_input_read_data[31:16];
                    k_dim  <= tb__dut__sram_input_read_data[15:0];
                    n_dim  <= tb__dut__sram_weight_read_data[15:0];
                    i_cnt  <= '0; j_cnt <= '0; k_cnt <= '0;
                    a_row  <= AW'(1); a_addr <= AW'(1);
                    b_col  <= AW'(1); b_addr <= AW'(1);
                    c_addr <= '0;
                    acc    <= '0;
                    pend   <= 1'b0;
                end
                S_MAC: begin
                    pend <= issue;
                    if (issue) begin
                        a_addr <= a_addr + AW'(1);
                        b_addr <= b_addr + AW'(n_dim);
                        k_cnt  <= k_cnt + 16'd1;
                    end
                    if (pend) acc <= acc_sum;
                end
                S_WRITE: begin
                    acc    <= '0;
                    pend   <= 1'b0;
                    k_cnt  <= '0;
                    c_addr <= c_addr + AW'(1);
                    if (last_col) begin
                        j_cnt  <= '0;
                        i_cnt  <= i_cnt + 16'd1;
                        a_row  <= a_row + AW'(k_dim);
                        a_addr <= a_row + AW'(k_dim);
                        b_col  <= AW'(1);
                        b_addr <= AW'(1);
                    end else begin
                        j_cnt  <= j_cnt + 16'd1;
                        a_addr <= a_row;
                        b_col  <= b_col + AW'(1);
                        b_addr <= b_col + AW'(1);
                    end
                end
                default: pend <= 1'b0;
            endcase
        end
    end

endmodule

// File: tb/tb_my_design.sv
// Directed bench for my_design: SRAM models, hand-computed fp32 results.
// Covers reset state, several matrix shapes, rounding/special values, abort and restart.
// Every wait on the DUT is cycle-bounded.
module tb_my_design;

    logic        clk = 1'b0;
    logic        reset_n;
    logic        dut_valid;
    logic        dut_ready;
    logic        in_we, w_we, res_we;
    logic [15:0] in_wa, w_wa, res_wa, in_ra, w_ra, res_ra;
    logic [31:0] in_wd, w_wd, res_wd, in_rd, w_rd, res_rd;

    logic [31:0] in_mem  [0:1023];
    logic [31:0] w_mem   [0:1023];
    logic [31:0] res_mem [0:1023];
    int          wr_cnt = 0;
    int          total  = 0;
    int          bad    = 0;
    int          busy, writes, w0;

    always #5 clk = ~clk;

    my_design dut (
        .clk                                (clk),
        .reset_n                            (reset_n),
        .dut_valid                          (dut_valid),
        .dut_ready                          (dut_ready),
        .dut__tb__sram_input_write_enable   (in_we),
        .dut__tb__sram_input_write_address  (in_wa),
        .dut__tb__sram_input_write_data     (in_wd),
        .dut__tb__sram_input_read_address   (in_ra),
        .tb__dut__sram_input_read_data      (in_rd),
        .dut__tb__sram_weight_write_enable  (w_we),
        .dut__tb__sram_weight_write_address (w_wa),
        .dut__tb__sram_weight_write_data    (w_wd),
        .dut__tb__sram_weight_read_address  (w_ra),
        .tb__dut__sram_weight_read_data     (w_rd),
        .dut__tb__sram_result_write_enable  (res_we),
        .dut__tb__sram_result_write_address (res_wa),
        .dut__tb__sram_result_write_data    (res_wd),
        .dut__tb__sram_result_read_address  (res_ra),
        .tb__dut__sram_result_read_data     (res_rd)
    );

    // Synchronous SRAMs: one-cycle read latency, write on the edge.
    always @(posedge clk) begin
        in_rd  <= in_mem[in_ra[9:0]];
        w_rd   <= w_mem[w_ra[9:0]];
        res_rd <= res_mem[res_ra[9:0]];
        if (res_we) begin
            res_mem[res_wa[9:0]] <= res_wd;
            wr_cnt <= wr_cnt + 1;
        end
    end

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        total++;
        if (got !== exp) begin
            bad++;
            $display("FAIL %s got=%h exp=%h", tag, got, exp);
        end
    endtask

    task automatic clear_res();
        for (int a = 0; a < 1024; a++) res_mem[a] = 32'hDEAD_BEEF;
    endtask

    // Start one job, wait (bounded) for dut_ready, check handshake and latency bound.
    task automatic run_mm(input string tag, input int m, input int k, input int n, input int kp,
                          output int nbusy, output int nwr);
        int start;
        in_mem[0] = {m[15:0], k[15:0]};
        w_mem[0]  = {kp[15:0], n[15:0]};
        start = wr_cnt;
        @(negedge clk);
        dut_valid = 1'b1;
        @(negedge clk);
        dut_valid = 1'b0;
        chk({tag, "_busy"}, {31'd0, dut_ready}, 32'd0);
        nbusy = 1;
        while (!dut_ready && nbusy < 20000) begin
            @(negedge clk);
            nbusy++;
        end
        nbusy--;
        chk({tag, "_done"}, {31'd0, dut_ready}, 32'd1);
        chk({tag, "_lat"}, {31'd0, nbusy <= m * n * (k + 3) + 6}, 32'd1);
        nwr = wr_cnt - start;
    endtask

    logic [31:0] sa [0:4];
    logic [31:0] sb [0:4];
    logic [31:0] se [0:4];

    initial begin
        for (int a = 0; a < 1024; a++) begin
            in_mem[a] = '0;
            w_mem[a]  = '0;
        end
        clear_res();
        reset_n   = 1'b1;
        dut_valid = 1'b0;
        repeat (3) @(negedge clk);
        chk("rst_ready", {31'd0, dut_ready}, 32'd1);
        chk("rst_we",    {31'd0, res_we}, 32'd0);
        chk("rst_wa",    {16'd0, res_wa}, 32'd0);
        chk("rst_wd",    res_wd, 32'd0);
        chk("rst_ra",    {in_ra, w_ra}, 32'd0);
        reset_n = 1'b0;
        @(negedge clk);

        // 2x2 identity times B
        in_mem[1] = 32'h3F80_0000; in_mem[2] = 32'h0000_0000;
        in_mem[3] = 32'h0000_0000; in_mem[4] = 32'h3F80_0000;
        w_mem[1]  = 32'h3FC0_0000; w_mem[2]  = 32'h4000_0000;
        w_mem[3]  = 32'hC040_0000; w_mem[4]  = 32'h4088_0000;
        run_mm("ident", 2, 2, 2, 2, busy, writes);
        chk("ident_c0", res_mem[0], 32'h3FC0_0000);
        chk("ident_c1", res_mem[1], 32'h4000_0000);
        chk("ident_c2", res_mem[2], 32'hC040_0000);
        chk("ident_c3", res_mem[3], 32'h4088_0000);
        chk("ident_nwr", writes, 32'd4);

        // 1x1x1 cases: plain, denormal flush, overflow, inf*0, RNE in product
        sa[0] = 32'h4000_0000; sb[0] = 32'h4040_0000; se[0] = 32'h40C0_0000;
        sa[1] = 32'h0040_0000; sb[1] = 32'h4000_0000; se[1] = 32'h0000_0000;
        sa[2] = 32'h7F00_0000; sb[2] = 32'h4000_0000; se[2] = 32'h7F80_0000;
        sa[3] = 32'h7F80_0000; sb[3] = 32'h0000_0000; se[3] = 32'h7FC0_0000;
        sa[4] = 32'h3F80_0001; sb[4] = 32'hBF80_0001; se[4] = 32'hBF80_0002;
        for (int t = 0; t < 5; t++) begin
            clear_res();
            in_mem[1] = sa[t];
            w_mem[1]  = sb[t];
            run_mm($sformatf("one%0d", t), 1, 1, 1, 1, busy, writes);
            chk($sformatf("one%0d_c", t), res_mem[0], se[t]);
            chk($sformatf("one%0d_nwr", t), writes, 32'd1);
        end

        // 2x3 times 3x2
        clear_res();
        for (int a = 0; a < 6; a++) begin
            in_mem[1 + a] = 32'h3F80_0000;
            w_mem[1 + a]  = 32'h3F80_0000;
        end
        in_mem[1] = 32'h3F80_0000; in_mem[2] = 32'h4000_0000; in_mem[3] = 32'h4040_0000;
        in_mem[4] = 32'h4080_0000; in_mem[5] = 32'h40A0_0000; in_mem[6] = 32'h40C0_0000;
        w_mem[1]  = 32'h40E0_0000; w_mem[2]  = 32'h4100_0000; w_mem[3]  = 32'h4110_0000;
        w_mem[4]  = 32'h4120_0000; w_mem[5]  = 32'h4130_0000; w_mem[6]  = 32'h4140_0000;
        run_mm("mm23", 2, 3, 2, 3, busy, writes);
        chk("mm23_c0", res_mem[0], 32'h4268_0000);
        chk("mm23_c1", res_mem[1], 32'h4280_0000);
        chk("mm23_c2", res_mem[2], 32'h430B_0000);
        chk("mm23_c3", res_mem[3], 32'h431A_0000);
        chk("mm23_c4", res_mem[4], 32'hDEAD_BEEF);
        chk("mm23_nwr", writes, 32'd4);

        // back-to-back: 2x2 overwrites the previous result set
        in_mem[1] = 32'h3F80_0000; in_mem[2] = 32'h4000_0000;
        in_mem[3] = 32'h4040_0000; in_mem[4] = 32'h4080_0000;
        w_mem[1]  = 32'h3F00_0000; w_mem[2]  = 32'hBF80_0000;
        w_mem[3]  = 32'h4000_0000; w_mem[4]  = 32'h3E80_0000;
        run_mm("b2b", 2, 2, 2, 2, busy, writes);
        chk("b2b_c0", res_mem[0], 32'h4090_0000);
        chk("b2b_c1", res_mem[1], 32'hBF00_0000);
        chk("b2b_c2", res_mem[2], 32'h4118_0000);
        chk("b2b_c3", res_mem[3], 32'hC000_0000);

        // round-to-nearest-even tie in the accumulate: (1+ulp) + 2^-24
        clear_res();
        in_mem[1] = 32'h3F80_0000; in_mem[2] = 32'h3F80_0000;
        w_mem[1]  = 32'h3F80_0001; w_mem[2]  = 32'h3380_0000;
        run_mm("rne", 1, 2, 1, 2, busy, writes);
        chk("rne_c0", res_mem[0], 32'h3F80_0002);

        // abort in MAC, then restart
        in_mem[0] = 32'h0002_0002; w_mem[0] = 32'h0002_0002;
        w0 = wr_cnt;
        @(negedge clk);
        dut_valid = 1'b1;
        @(negedge clk);
        dut_valid = 1'b0;
        repeat (2) @(negedge clk);
        reset_n = 1'b1;
        @(negedge clk);
        chk("abort_ready", {31'd0, dut_ready}, 32'd1);
        chk("abort_we", {31'd0, res_we}, 32'd0);
        reset_n = 1'b0;
        repeat (3) @(negedge clk);
        chk("abort_nwr", wr_cnt - w0, 32'd0);
        clear_res();
        in_mem[1] = 32'h4000_0000;
        w_mem[1]  = 32'h4040_0000;
        run_mm("restart", 1, 1, 1, 1, busy, writes);
        chk("restart_c0", res_mem[0], 32'h40C0_0000);

`ifdef DIM_CHECK_EN
        clear_res();
        run_mm("dimchk", 2, 3, 2, 2, busy, writes);
        chk("dimchk_nwr", writes, 32'd0);
        chk("dimchk_lat", {31'd0, busy <= 3}, 32'd1);
`endif

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
